// File: rtl/synth_voice_mixer.sv
// Polyphonic voice bank: applies note-bus events to voice slots, runs each voice's
// phase accumulator once per sample tick, and mixes all voices into one signed sample.
//
// state | meaning
// IDLE  | wait for a pending event (served first) or a pending sample tick
// APPLY | note event has been applied to the voice slots
// SCAN  | voice r_idx is accumulated into the mix and its phase advanced
// OUT   | mixed sample presented with oSampleValid
module synth_voice_mixer #(
    parameter int NUM_VOICES = 8,
    parameter int PHASE_W    = 24,
    parameter int FS_HZ      = 48000
) (
    input  logic                  CLK,
    input  logic                  Reset_n,
    input  logic                  iSampleTick,
    input  logic [7:0]            iSynth,
    input  logic [6:0]            iSynthVolume,
    input  logic [3:0]            iSynthInst,
    input  logic                  iPause,
    output logic [15:0]           oSample,
    output logic                  oSampleValid,
    output logic [NUM_VOICES-1:0] oActiveVoices,
    output logic                  oOverrun,
    output logic                  oEventDrop
);
    localparam int IW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

    // Increment for a pitch-class in octave 0, rounded; f_uhz is the note frequency in micro-Hz.
    function automatic logic [PHASE_W-1:0] calc_inc(input longint f_uhz);
        longint num;
        num = (f_uhz <<< PHASE_W) + longint'(FS_HZ) * 64'sd500000;
        calc_inc = PHASE_W'(num / (longint'(FS_HZ) * 64'sd1000000));
    endfunction

    localparam logic [PHASE_W-1:0] INC_TAB [16] = '{
        calc_inc(64'sd8175799),  calc_inc(64'sd8661957),  calc_inc(64'sd9177024),
        calc_inc(64'sd9722718),  calc_inc(64'sd10300861), calc_inc(64'sd10913382),
        calc_inc(64'sd11562326), calc_inc(64'sd12249857), calc_inc(64'sd12978272),
        calc_inc(64'sd13750000), calc_inc(64'sd14567618), calc_inc(64'sd15433853),
        '0, '0, '0, '0
    };

    function automatic logic signed [7:0] wave_fn(input logic [1:0] sel, input logic [7:0] p);
        logic [8:0] tri2;
        tri2 = {1'b0, p[6:0], 1'b0};
        case (sel)
            2'd0:    wave_fn = p[7] ? -8'sd127 : 8'sd127;
            2'd1:    wave_fn = $signed(p ^ 8'h80);
            2'd2:    wave_fn = p[7] ? $signed(8'(9'd127 - tri2)) : $signed(8'(tri2 - 9'd128));
            default: wave_fn = (p[7:6] == 2'b00) ? 8'sd127 : -8'sd127;
        endcase
    endfunction

    typedef enum logic [1:0] {S_IDLE, S_APPLY, S_SCAN, S_OUT} state_t;

    state_t                  r_state;
    logic [18:0]             r_prev;
    logic                    r_ev_pend;
    logic                    r_tick_pend;
    logic [IW-1:0]           r_idx;
    logic [IW-1:0]           r_steal;
    logic signed [17:0]      r_acc;
    logic [NUM_VOICES-1:0]   r_active;
    logic [6:0]              r_pitch [NUM_VOICES];
    logic [6:0]              r_vol   [NUM_VOICES];
    logic [1:0]              r_wave  [NUM_VOICES];
    logic [PHASE_W-1:0]      r_inc   [NUM_VOICES];
    logic [PHASE_W-1:0]      r_phase [NUM_VOICES];
    logic [15:0]             r_sample;
    logic                    r_valid;
    logic                    r_overrun;
    logic                    r_drop;

    logic [18:0]             w_bus;
    logic [6:0]              w_pitch;
    logic                    w_on;
    logic [3:0]              w_semi;
    logic [3:0]              w_oct;
    logic [PHASE_W-1:0]      w_inc;
    logic [NUM_VOICES-1:0]   w_match;
    logic                    w_any_free;
    logic [IW-1:0]           w_free_idx;
    logic [IW-1:0]           w_slot;
    logic                    w_ev_take;
    logic                    w_tick_take;
    logic                    w_run;
    logic signed [7:0]       w_wave;
    logic signed [15:0]      w_prod;
    logic signed [17:0]      w_acc_next;
    logic signed [17:0]      w_acc_shr;

    assign w_bus       = {iSynthInst, iSynthVolume, iSynth};
    assign w_pitch     = r_prev[7:1];
    assign w_on        = r_prev[0];
    assign w_semi      = 4'(w_pitch % 7'd12);
    assign w_oct       = 4'(w_pitch / 7'd12);
    assign w_inc       = INC_TAB[w_semi] << w_oct;
    assign w_slot      = w_any_free ? w_free_idx : r_steal;
    assign w_ev_take   = (r_state == S_IDLE) && r_ev_pend;
    assign w_tick_take = (r_state == S_IDLE) && !r_ev_pend && r_tick_pend;

    always_comb begin
        w_match    = '0;
        w_any_free = 1'b0;
        w_free_idx = '0;
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            w_match[i] = r_active[i] && (r_pitch[i] == w_pitch);
            if (!r_active[i]) begin
                w_any_free = 1'b1;
                w_free_idx = IW'(i);
            end
        end
    end

    // Phase index is taken before the increment, so sample k uses phase (k-1)*inc.
    assign w_run      = r_active[r_idx] && !iPause;
    assign w_wave     = wave_fn(r_wave[r_idx], r_phase[r_idx][PHASE_W-1 -: 8]);
    assign w_prod     = w_wave * $signed({1'b0, r_vol[r_idx]});
    assign w_acc_next = r_acc + (w_run ? {{2{w_prod[15]}}, w_prod} : 18'sd0);
    assign w_acc_shr  = w_acc_next >>> 2;

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state     <= S_IDLE;
            r_prev      <= '0;
            r_ev_pend   <= 1'b0;
            r_tick_pend <= 1'b0;
            r_idx       <= '0;
            r_steal     <= '0;
            r_acc       <= '0;
            r_active    <= '0;
            r_sample    <= '0;
            r_valid     <= 1'b0;
            r_overrun   <= 1'b0;
            r_drop      <= 1'b0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                r_pitch[i] <= '0;
                r_vol[i]   <= '0;
                r_wave[i]  <= '0;
                r_inc[i]   <= '0;
                r_phase[i] <= '0;
            end
        end else begin
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
            r_drop    <= 1'b0;

            if (w_bus != r_prev) begin
                r_prev    <= w_bus;
                r_ev_pend <= 1'b1;
                if (r_ev_pend && !w_ev_take)
                    r_drop <= 1'b1;
            end else if (w_ev_take) begin
                r_ev_pend <= 1'b0;
            end

            if (iSampleTick && r_tick_pend)
                r_overrun <= 1'b1;
            if (w_tick_take)
                r_tick_pend <= 1'b0;
            else if (iSampleTick)
                r_tick_pend <= 1'b1;

            case (r_state)
                S_IDLE: begin
                    if (r_ev_pend) begin
                        r_state <= S_APPLY;
                        if (w_on) begin
                            if (|w_match) begin
                                for (int i = 0; i < NUM_VOICES; i++) begin
                                    if (w_match[i]) begin
                                        r_vol[i]   <= r_prev[14:8];
                                        r_wave[i]  <= r_prev[16:15];
                                        r_phase[i] <= '0;
                                    end
                                end
                            end else begin
                                r_active[w_slot] <= 1'b1;
                                r_pitch[w_slot]  <= w_pitch;
                                r_vol[w_slot]    <= r_prev[14:8];
                                r_wave[w_slot]   <= r_prev[16:15];
                                r_inc[w_slot]    <= w_inc;
                                r_phase[w_slot]  <= '0;
                                if (!w_any_free)
                                    r_steal <= (r_steal == IW'(NUM_VOICES - 1)) ? '0 : r_steal + 1'b1;
                            end
                        end else begin
                            r_active <= r_active & ~w_match;
                        end
                    end else if (r_tick_pend) begin
                        r_state <= S_SCAN;
                        r_idx   <= '0;
                        r_acc   <= '0;
                    end
                end
                S_APPLY: r_state <= S_IDLE;
                S_SCAN: begin
                    r_acc <= w_acc_next;
                    if (w_run)
                        r_phase[r_idx] <= r_phase[r_idx] + r_inc[r_idx];
                    if (r_idx == IW'(NUM_VOICES - 1)) begin
                        r_state  <= S_OUT;
                        r_sample <= w_acc_shr[15:0];
                        r_valid  <= 1'b1;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign oSample       = r_sample;
    assign oSampleValid  = r_valid;
    assign oActiveVoices = r_active;
    assign oOverrun      = r_overrun;
    assign oEventDrop    = r_drop;

endmodule

// File: tb/tb_synth_voice_mixer.sv
// Directed bench for synth_voice_mixer: hand-computed samples, voice allocation,
// stealing, pause, overrun, event drop and reset behaviour.
module tb_synth_voice_mixer;
    logic        CLK = 1'b0;
    logic        Reset_n = 1'b0;
    logic        iSampleTick = 1'b0;
    logic [7:0]  iSynth = '0;
    logic [6:0]  iSynthVolume = '0;
    logic [3:0]  iSynthInst = '0;
    logic        iPause = 1'b0;
    logic [15:0] oSample;
    logic        oSampleValid;
    logic [7:0]  oActiveVoices;
    logic        oOverrun;
    logic        oEventDrop;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int t_cyc = 0;
    int last_lat = 0;
    int n_valid = 0;
    int n_ovr = 0;
    int n_drop = 0;
    int base_v, base_o, base_d;

    synth_voice_mixer dut (
        .CLK(CLK), .Reset_n(Reset_n), .iSampleTick(iSampleTick),
        .iSynth(iSynth), .iSynthVolume(iSynthVolume), .iSynthInst(iSynthInst),
        .iPause(iPause), .oSample(oSample), .oSampleValid(oSampleValid),
        .oActiveVoices(oActiveVoices), .oOverrun(oOverrun), .oEventDrop(oEventDrop)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;
    always @(negedge CLK) begin
        if (oSampleValid) n_valid++;
        if (oOverrun) n_ovr++;
        if (oEventDrop) n_drop++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic note(input int pitch, input bit on, input int vol, input int inst);
        @(posedge CLK); #1;
        iSynth = {7'(pitch), on};
        iSynthVolume = 7'(vol);
        iSynthInst = 4'(inst);
        step(4);
    endtask

    task automatic wait_sample(input string tag, input int exp);
        bit got;
        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            if (oSampleValid) got = 1'b1;
            else step(1);
        end
        if (got) begin
            last_lat = cyc - t_cyc;
            chk(tag, $signed(oSample), exp);
            step(1);
        end else begin
            chk({tag, "_strobe"}, 0, 1);
        end
    endtask

    task automatic tick_sample(input string tag, input int exp);
        @(posedge CLK); #1;
        iSampleTick = 1'b1;
        t_cyc = cyc;
        step(1);
        iSampleTick = 1'b0;
        wait_sample(tag, exp);
    endtask

    initial begin
        step(3);
        chk("rst_sample", oSample, 0);
        chk("rst_valid", oSampleValid, 0);
        chk("rst_active", oActiveVoices, 0);
        chk("rst_flags", {oOverrun, oEventDrop}, 0);
        Reset_n = 1'b1;
        step(2);

        // single square voice, pitch 69, full volume: +127*127 >>> 2 = 4032
        note(69, 1, 127, 0);
        chk("t1_active", oActiveVoices, 8'h01);
        tick_sample("t1_sample", 4032);
        chk("t1_latency", last_lat, 10);

        // phase crosses 2^23 at sample 56; pause in between must not advance phase
        for (int k = 2; k <= 54; k++) tick_sample("t2_pos", 4032);
        iPause = 1'b1;
        tick_sample("t6_pause_a", 0);
        tick_sample("t6_pause_b", 0);
        iPause = 1'b0;
        tick_sample("t6_resume_s55", 4032);
        tick_sample("t2_s56", -4033);

        note(69, 0, 127, 0);
        chk("t4_active", oActiveVoices, 0);
        tick_sample("t4_silent", 0);

        // event and tick together: the new voice is in that sample
        @(posedge CLK); #1;
        iSynth = {7'd69, 1'b1};
        iSampleTick = 1'b1;
        step(1);
        iSampleTick = 1'b0;
        wait_sample("evtick_sample", 4032);
        chk("evtick_active", oActiveVoices, 8'h01);

        base_v = n_valid; base_o = n_ovr;
        @(posedge CLK); #1;
        iSampleTick = 1'b1;
        step(3);
        iSampleTick = 1'b0;
        step(40);
        chk("t5_strobes", n_valid - base_v, 2);
        chk("t5_overruns", n_ovr - base_o, 1);

        base_v = n_valid;
        @(posedge CLK); #1;
        iSampleTick = 1'b1;
        step(1);
        iSampleTick = 1'b0;
        step(4);
        Reset_n = 1'b0;
        iSynth = '0; iSynthVolume = '0; iSynthInst = '0;
        step(2);
        chk("midrst_active", oActiveVoices, 0);
        Reset_n = 1'b1;
        step(20);
        chk("midrst_no_strobe", n_valid - base_v, 0);
        chk("midrst_sample", oSample, 0);

        // other waveforms; second sample sits at index p = 2
        note(69, 1, 127, 1);
        tick_sample("saw_p0", -4064);
        tick_sample("saw_p2", -4001);
        note(69, 1, 127, 2);
        tick_sample("tri_p0", -4064);
        tick_sample("tri_p2", -3937);
        note(69, 1, 127, 3);
        tick_sample("pulse_p0", 4032);
        chk("retrig_active", oActiveVoices, 8'h01);

        note(69, 0, 127, 3);
        note(57, 1, 64, 0);
        note(69, 1, 127, 0);
        chk("mix_active", oActiveVoices, 8'h03);
        tick_sample("mix_sample", 6064);
        note(57, 0, 64, 0);
        note(69, 0, 127, 0);
        chk("mix_off", oActiveVoices, 0);

        // fill, steal voice 0, then next steal must land on voice 1
        for (int p = 60; p <= 67; p++) note(p, 1, 100, 0);
        chk("t3_full", oActiveVoices, 8'hFF);
        note(68, 1, 100, 0);
        chk("t3_steal0", oActiveVoices, 8'hFF);
        note(60, 0, 100, 0);
        chk("t3_off_stolen", oActiveVoices, 8'hFF);
        note(68, 0, 100, 0);
        chk("t3_v0_was_68", oActiveVoices, 8'hFE);
        note(68, 1, 100, 0);
        chk("t3_refill_v0", oActiveVoices, 8'hFF);
        note(69, 1, 100, 0);
        note(69, 0, 100, 0);
        chk("t3_steal1", oActiveVoices, 8'hFD);
        note(62, 1, 50, 0);
        chk("retrig_no_alloc", oActiveVoices, 8'hFD);

        // two events during one scan: the first is overwritten
        base_d = n_drop;
        @(posedge CLK); #1;
        iSampleTick = 1'b1;
        step(1);
        iSampleTick = 1'b0;
        step(2);
        iSynth = {7'd70, 1'b1};
        step(1);
        iSynth = {7'd71, 1'b1};
        step(20);
        chk("drop_count", n_drop - base_d, 1);
        chk("drop_applied", oActiveVoices, 8'hFF);
        note(71, 0, 50, 0);
        chk("drop_v1_71", oActiveVoices, 8'hFD);
        note(70, 0, 50, 0);
        chk("drop_70_lost", oActiveVoices, 8'hFD);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
